// File: rtl/vospi_pkg.sv
// Shared VoSPI types: frame geometry, pixel word and the tagged pixel carried to the frame-buffer writer.
package vospi_pkg;

    localparam int unsigned frame_width_c  = 80;
    localparam int unsigned frame_height_c = 60;
    localparam int unsigned x_w_c          = $clog2(frame_width_c);
    localparam int unsigned y_w_c          = $clog2(frame_height_c);

    typedef logic [15:0] pixel_t;

    typedef struct packed {
        pixel_t             pixel;
        logic [x_w_c-1:0]   x;
        logic [y_w_c-1:0]   y;
        logic               sof;
        logic               eol;
        logic               eof;
    } pixel_tag_t;

    // Pixels travel big-endian on the wire: the first byte is the MSB.
    function automatic pixel_t pack_pixel(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/vospi_pixel_fifo.sv
// First-word fall-through FIFO of tagged pixels with flush; the head reads as zero while empty.
module vospi_pixel_fifo
    import vospi_pkg::*;
#(
    parameter int unsigned depth_p = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  pixel_tag_t data_i,
    output pixel_tag_t data_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int unsigned ptr_w = $clog2(depth_p);
    localparam int unsigned cnt_w = ptr_w + 1;

    pixel_tag_t       mem_q [depth_p];
    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop_i & ~empty_q;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push  = push_i & (~full_q | do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ptr_w'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_w'(1);
            cnt_d = cnt_q + cnt_w'(do_push) - cnt_w'(do_pop);
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == cnt_w'(depth_p));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !reset_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/vospi_pixel_assembler.sv
// Pairs VoSPI payload bytes into big-endian pixels, tags them with position/frame markers
// and hands them to the frame-buffer writer through a small FIFO, dropping on overflow.
module vospi_pixel_assembler
    import vospi_pkg::*;
#(
    parameter int unsigned frame_width_p  = frame_width_c,
    parameter int unsigned frame_height_p = frame_height_c,
    parameter int unsigned fifo_depth_p   = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [7:0]                        data_i,
    input  logic                              valid_i,
    input  logic                              resync_i,
    input  logic                              ready_i,
    output logic                              valid_o,
    output logic [15:0]                       pixel_o,
    output logic [$clog2(frame_width_p)-1:0]  x_o,
    output logic [$clog2(frame_height_p)-1:0] y_o,
    output logic                              sof_o,
    output logic                              eol_o,
    output logic                              eof_o,
    output logic                              overflow_o,
    output logic [15:0]                       frame_cnt_o
);

    localparam int unsigned x_w = $clog2(frame_width_p);
    localparam int unsigned y_w = $clog2(frame_height_p);

    logic             phase_q, phase_d;
    logic [7:0]       hi_q, hi_d;
    logic [x_w_c-1:0] x_q, x_d;
    logic [y_w_c-1:0] y_q, y_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic             formed_c;
    logic             pop_c;
    logic             push_c;
    logic             last_col_c;
    logic             last_row_c;
    logic             fifo_empty;
    logic             fifo_full;
    pixel_tag_t       tag_c;
    pixel_tag_t       head;

    // Pairing, tagging, counters and overflow tracking.
    always_comb begin
        phase_d     = phase_q;
        hi_d        = hi_q;
        x_d         = x_q;
        y_d         = y_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;

        formed_c   = valid_i & phase_q & ~resync_i;
        pop_c      = ~fifo_empty & ready_i;
        push_c     = formed_c & (~fifo_full | pop_c);
        last_col_c = (x_q == x_w_c'(frame_width_p - 1));
        last_row_c = (y_q == y_w_c'(frame_height_p - 1));

        tag_c.pixel = pack_pixel(hi_q, data_i);
        tag_c.x     = x_q;
        tag_c.y     = y_q;
        tag_c.sof   = (x_q == '0) && (y_q == '0);
        tag_c.eol   = last_col_c;
        tag_c.eof   = last_col_c & last_row_c;

        if (resync_i) begin
            phase_d    = 1'b0;
            x_d        = '0;
            y_d        = '0;
            overflow_d = 1'b0;
        end else if (valid_i) begin
            if (!phase_q) begin
                hi_d    = data_i;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                // Position advances even for dropped pixels so the frame stays aligned.
                if (last_col_c) begin
                    x_d = '0;
                    if (last_row_c) begin
                        y_d         = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        y_d = y_q + y_w_c'(1);
                    end
                end else begin
                    x_d = x_q + x_w_c'(1);
                end
                if (!push_c) overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q     <= 1'b0;
            hi_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            x_q         <= x_d;
            y_q         <= y_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    vospi_pixel_fifo #(
        .depth_p (fifo_depth_p)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (resync_i),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .data_i  (tag_c),
        .data_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign valid_o     = ~fifo_empty;
    assign pixel_o     = head.pixel;
    assign x_o         = x_w'(head.x);
    assign y_o         = y_w'(head.y);
    assign sof_o       = head.sof;
    assign eol_o       = head.eol;
    assign eof_o       = head.eof;
    assign overflow_o  = overflow_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
